btb_predictor: RTL and testbench

Parametrised branch target buffer with 2-bit saturating direction counters and an optional return address stack. It sits between IF and ID. IF reads a prediction for the fetch PC in the same cycle. ID's branch resolution drives the training port at the next clock edge. It replaces the fixed single-bit predictor interface (`pre_token`/`pre_addr` in, `set`/`set_pc`/`set_taken`/`set_target` out) with a sized, tagged, trainable table.

---
 rtl/btb_predictor_pkg.sv | 25 ++
 rtl/btb_ras.sv | 66 ++++++
 rtl/btb_predictor.sv | 180 ++++++++++++++++++
 tb/tb_btb_predictor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_predictor_pkg.sv
// Shared types for the branch target buffer: direction-counter encodings and clear-FSM states.
// Define BTB_RAS_EN at compile time to build in the return address stack; it is left undefined by default.
package btb_predictor_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } ctr_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } btb_state_e;

    function automatic ctr_e ctr_inc(input ctr_e c);
        return (c == STRONG_T) ? STRONG_T : ctr_e'(c + 2'd1);
    endfunction

    function automatic ctr_e ctr_dec(input ctr_e c);
        return (c == STRONG_NT) ? STRONG_NT : ctr_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/btb_ras.sv
// Return address stack: circular buffer whose count saturates at DEPTH, so overflow drops the oldest entry.
// Compiled into btb_predictor only when BTB_RAS_EN is defined.
module btb_ras
    import btb_predictor_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    output logic [ADDR_WIDTH-1:0] top,
    output logic                  empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      top_ptr_c;

    always_comb begin
        top_ptr_c = ptr_q - PTR_W'(1);
        top       = mem_q[top_ptr_c];
        empty     = (count_q == '0);
    end

    // ptr_q names the next free slot; push+pop together replaces the top in place
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (push && pop && !empty) begin
            mem_d[top_ptr_c] = push_addr;
        end else if (push) begin
            mem_d[ptr_q] = push_addr;
            ptr_d        = ptr_q + PTR_W'(1);
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_d   = top_ptr_c;
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/btb_predictor.sv
// Tagged branch target buffer with 2-bit direction counters and a sweeping clear FSM.
// Optional return address stack built in when BTB_RAS_EN is defined.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int unsigned ENTRY_NUM  = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned RAS_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  pre_taken,
    output logic [ADDR_WIDTH-1:0] pre_addr,
    input  logic                  set,
    input  logic [ADDR_WIDTH-1:0] set_pc,
    input  logic                  set_taken,
    input  logic [ADDR_WIDTH-1:0] set_target,
    input  logic                  set_is_call,
    input  logic                  set_is_ret,
    input  logic                  clear,
    output logic                  busy
);

    localparam int unsigned IDX_W = $clog2(ENTRY_NUM);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - 2;
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [ENTRY_NUM-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q    [ENTRY_NUM];
    logic [TAG_W-1:0]      tag_d    [ENTRY_NUM];
    logic [ADDR_WIDTH-1:0] target_q [ENTRY_NUM];
    logic [ADDR_WIDTH-1:0] target_d [ENTRY_NUM];
    ctr_e                  ctr_q    [ENTRY_NUM];
    ctr_e                  ctr_d    [ENTRY_NUM];

    btb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      sweep_idx_q, sweep_idx_d;
    logic                  sweeping_c;

    logic [IDX_W-1:0]      lk_idx_c, st_idx_c;
    logic [TAG_W-1:0]      lk_tag_c, st_tag_c;
    logic                  lk_hit_c, st_hit_c;

`ifdef BTB_RAS_EN
    logic [ENTRY_NUM-1:0]  ret_q, ret_d;
    logic [ADDR_WIDTH-1:0] ras_top_c;
    logic                  ras_empty_c;

    // Calls push the return address past the delay slot; the stack keeps running during a sweep
    btb_ras #(
        .DEPTH      (RAS_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (set && set_is_call && set_taken),
        .pop       (set && set_is_ret),
        .push_addr (set_pc + ADDR_WIDTH'(8)),
        .top       (ras_top_c),
        .empty     (ras_empty_c)
    );
`else
    logic unused_c;
    assign unused_c = ^{set_is_call, set_is_ret, set_pc[1:0], 32'(RAS_DEPTH)};
`endif

    always_comb begin
        lk_idx_c = lookup_pc[IDX_W+1:2];
        lk_tag_c = lookup_pc[ADDR_WIDTH-1:IDX_W+2];
        st_idx_c = set_pc[IDX_W+1:2];
        st_tag_c = set_pc[ADDR_WIDTH-1:IDX_W+2];
        lk_hit_c = valid_q[lk_idx_c] && (tag_q[lk_idx_c] == lk_tag_c);
        st_hit_c = valid_q[st_idx_c] && (tag_q[st_idx_c] == st_tag_c);
    end

    // Prediction reads pre-write table contents; no bypass from the training port
    always_comb begin
        pre_taken = lk_hit_c && (ctr_q[lk_idx_c] >= WEAK_T) && !sweeping_c;
        pre_addr  = lookup_pc + ADDR_WIDTH'(4);
        if (pre_taken) begin
            pre_addr = target_q[lk_idx_c];
`ifdef BTB_RAS_EN
            if (ret_q[lk_idx_c] && !ras_empty_c) begin
                pre_addr = ras_top_c;
            end
`endif
        end
    end

    // Training, or one valid bit cleared per cycle while sweeping
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
`ifdef BTB_RAS_EN
        ret_d    = ret_q;
`endif
        if (sweeping_c) begin
            valid_d[sweep_idx_q[IDX_W-1:0]] = 1'b0;
        end else if (set) begin
            if (st_hit_c) begin
                if (set_taken) begin
                    ctr_d[st_idx_c]    = ctr_inc(ctr_q[st_idx_c]);
                    target_d[st_idx_c] = set_target;
`ifdef BTB_RAS_EN
                    ret_d[st_idx_c]    = set_is_ret;
`endif
                end else begin
                    ctr_d[st_idx_c] = ctr_dec(ctr_q[st_idx_c]);
                end
            end else if (set_taken) begin
                valid_d[st_idx_c]  = 1'b1;
                tag_d[st_idx_c]    = st_tag_c;
                target_d[st_idx_c] = set_target;
                ctr_d[st_idx_c]    = WEAK_T;
`ifdef BTB_RAS_EN
                ret_d[st_idx_c]    = set_is_ret;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        ctr_q    <= ctr_d;
`ifdef BTB_RAS_EN
        ret_q    <= ret_d;
`endif
    end

    // Clear FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // Clear FSM: next state; clear is ignored once a sweep is running
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d     = SWEEP;
                    sweep_idx_d = '0;
                end
            end
            SWEEP: begin
                sweep_idx_d = sweep_idx_q + CNT_W'(1);
                if (sweep_idx_q == CNT_W'(ENTRY_NUM - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear FSM: outputs
    always_comb begin
        sweeping_c = (state_q == SWEEP);
        busy       = sweeping_c;
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Randomized and directed bench for btb_predictor against a behavioural table/stack model.
// Return-stack scenarios are included when BTB_RAS_EN is defined.
module tb_btb_predictor;

    localparam int unsigned N     = 64;
    localparam int unsigned AW    = 32;
    localparam int unsigned D     = 8;
    localparam int unsigned IDX_W = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] lookup_pc;
    logic          pre_taken;
    logic [AW-1:0] pre_addr;
    logic          set;
    logic [AW-1:0] set_pc;
    logic          set_taken;
    logic [AW-1:0] set_target;
    logic          set_is_call;
    logic          set_is_ret;
    logic          clear;
    logic          busy;

    always #5 clk = ~clk;

    btb_predictor #(
        .ENTRY_NUM  (N),
        .ADDR_WIDTH (AW),
        .RAS_DEPTH  (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (lookup_pc),
        .pre_taken   (pre_taken),
        .pre_addr    (pre_addr),
        .set         (set),
        .set_pc      (set_pc),
        .set_taken   (set_taken),
        .set_target  (set_target),
        .set_is_call (set_is_call),
        .set_is_ret  (set_is_ret),
        .clear       (clear),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model: each slot remembers the full PC it was trained with; RAS is a bounded queue
    bit            m_valid [N];
    logic [AW-1:0] m_pc    [N];
    logic [AW-1:0] m_tgt   [N];
    int            m_ctr   [N];
    bit            m_ret   [N];
    int            m_left;
    logic [AW-1:0] m_ras [$];

    function automatic int idx_of(input logic [AW-1:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic bit m_hit(input logic [AW-1:0] pc);
        int i = idx_of(pc);
        return m_valid[i] && ((m_pc[i] >> (IDX_W + 2)) == (pc >> (IDX_W + 2)));
    endfunction

    function automatic bit exp_taken(input logic [AW-1:0] pc);
        return (m_left == 0) && m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] pc);
        int i = idx_of(pc);
        if (!exp_taken(pc)) return pc + 32'd4;
`ifdef BTB_RAS_EN
        if (m_ret[i] && m_ras.size() > 0) return m_ras[$];
`endif
        return m_tgt[i];
    endfunction

    task automatic model_update();
        int i;
        if (rst) begin
            foreach (m_valid[k]) m_valid[k] = 1'b0;
            m_left = 0;
            m_ras.delete();
            return;
        end
`ifdef BTB_RAS_EN
        if (set && set_is_call && set_taken) begin
            m_ras.push_back(set_pc + 32'd8);
            if (m_ras.size() > D) void'(m_ras.pop_front());
        end
        if (set && set_is_ret && m_ras.size() > 0) void'(m_ras.pop_back());
`endif
        if (m_left > 0) begin
            m_valid[N - m_left] = 1'b0;
            m_left--;
            return;
        end
        if (set) begin
            i = idx_of(set_pc);
            if (m_hit(set_pc)) begin
                if (set_taken) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = set_target;
                    m_ret[i] = set_is_ret;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (set_taken) begin
                m_valid[i] = 1'b1;
                m_pc[i]    = set_pc;
                m_tgt[i]   = set_target;
                m_ctr[i]   = 2;
                m_ret[i]   = set_is_ret;
            end
        end
        if (clear) m_left = N;
    endtask

    // One clock: compare combinational outputs at negedge, advance model at posedge
    task automatic cycle();
        @(negedge clk);
        chk("pre_taken", pre_taken, exp_taken(lookup_pc));
        chk("pre_addr", pre_addr, exp_addr(lookup_pc));
        chk("busy", busy, m_left > 0);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic quiet();
        rst = 0; set = 0; set_taken = 0; set_is_call = 0; set_is_ret = 0; clear = 0;
    endtask

    task automatic do_reset();
        rst = 1; cycle(); rst = 0;
    endtask

    task automatic train(input logic [AW-1:0] pc, input bit tk, input logic [AW-1:0] tgt,
                         input bit call, input bit ret);
        set = 1; set_pc = pc; set_taken = tk; set_target = tgt; set_is_call = call; set_is_ret = ret;
        cycle();
        set = 0; set_is_call = 0; set_is_ret = 0;
    endtask

    task automatic look(input string tag, input logic [AW-1:0] pc, input bit tk, input logic [AW-1:0] addr);
        lookup_pc = pc;
        #1;
        chk({tag, "_taken"}, pre_taken, tk);
        chk({tag, "_addr"}, pre_addr, addr);
    endtask

    function automatic logic [AW-1:0] pool_pc();
        return 32'h8000_0000 | (32'($urandom_range(0, 11)) << 2) | (32'($urandom_range(0, 2)) << (IDX_W + 2));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_busy;
        logic [AW-1:0] pc;
        quiet();
        set_pc = '0; set_target = '0; lookup_pc = '0; m_left = 0;
        rst = 1;
        repeat (2) begin @(posedge clk); model_update(); end
        #1;
        rst = 0;

        look("rst", 32'hBFC0_0000, 0, 32'hBFC0_0004);
        chk("rst_busy", busy, 0);

        train(32'h8000_1000, 1, 32'h8000_2000, 0, 0);
        look("train_t", 32'h8000_1000, 1, 32'h8000_2000);
        train(32'h8000_1000, 0, 32'h0, 0, 0);
        look("nt1", 32'h8000_1000, 0, 32'h8000_1004);
        train(32'h8000_1000, 0, 32'h0, 0, 0);
        look("nt2", 32'h8000_1000, 0, 32'h8000_1004);
        train(32'h8000_1000, 0, 32'h0, 0, 0);
        train(32'h8000_1000, 1, 32'h8000_2000, 0, 0);
        look("sat_lo", 32'h8000_1000, 0, 32'h8000_1004);
        repeat (3) train(32'h8000_1000, 1, 32'h8000_2000, 0, 0);
        train(32'h8000_1000, 0, 32'h0, 0, 0);
        look("sat_hi", 32'h8000_1000, 1, 32'h8000_2000);

        train(32'h8000_1000 + 4 * N, 1, 32'h8000_3000, 0, 0);
        look("alias_old", 32'h8000_1000, 0, 32'h8000_1004);
        look("alias_new", 32'h8000_1000 + 4 * N, 1, 32'h8000_3000);

        lookup_pc = 32'h8000_5000;
        set = 1; set_pc = 32'h8000_5000; set_taken = 1; set_target = 32'h8000_7000;
        #1;
        chk("nobypass", pre_taken, 0);
        cycle();
        set = 0;
        look("after_write", 32'h8000_5000, 1, 32'h8000_7000);
        look("wrap", 32'hFFFF_FFFC, 0, 32'h0000_0000);

        for (int i = 0; i < 8; i++) train(32'h8000_4000 + 4 * i, 1, 32'h8000_6000 + 16 * i, 0, 0);
        clear = 1; cycle(); clear = 0;
        n_busy = 0;
        for (int i = 0; i < N + 4; i++) begin
            if (busy) n_busy++;
            lookup_pc = 32'h8000_4000 + 4 * $urandom_range(0, 7);
            set = 1'($urandom_range(0, 1));
            set_pc = 32'h8000_8000 + 4 * $urandom_range(0, 15);
            set_taken = 1; set_target = $urandom;
            clear = (i < N - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            cycle();
        end
        quiet();
        chk("busy_len", n_busy, N);
        for (int i = 0; i < 8; i++) look("post_clear", 32'h8000_4000 + 4 * i, 0, 32'h8000_4004 + 4 * i);

        train(32'h8000_4000, 1, 32'h8000_6000, 0, 0);
        clear = 1; cycle(); clear = 0;
        repeat (5) cycle();
        do_reset();
        chk("rst_abort_busy", busy, 0);
        look("rst_abort_miss", 32'h8000_4000, 0, 32'h8000_4004);
        train(32'h8000_4000, 1, 32'h8000_6000, 0, 0);
        rst = 1; clear = 1; cycle(); quiet();
        chk("rst_wins_busy", busy, 0);

`ifdef BTB_RAS_EN
        do_reset();
        train(32'h8000_0310, 1, 32'h8000_0400, 0, 1);
        look("ret_empty", 32'h8000_0310, 1, 32'h8000_0400);
        train(32'h8000_0100, 1, 32'h8000_0500, 1, 0);
        train(32'h8000_0200, 1, 32'h8000_0600, 1, 0);
        look("ras_top2", 32'h8000_0310, 1, 32'h8000_0208);
        train(32'h8000_0314, 0, 32'h0, 0, 1);
        look("ras_pop1", 32'h8000_0310, 1, 32'h8000_0108);

        do_reset();
        train(32'h8000_0310, 1, 32'h8000_0400, 0, 1);
        for (int i = 0; i <= D; i++) train(32'h8001_0000 + 32'h100 * i, 1, 32'h8002_0000, 1, 0);
        look("ras_ovf_top", 32'h8000_0310, 1, 32'h8001_0000 + 32'h100 * D + 8);
        repeat (D - 1) train(32'h8000_0314, 0, 32'h0, 0, 1);
        look("ras_oldest", 32'h8000_0310, 1, 32'h8001_0108);
        train(32'h8000_0314, 0, 32'h0, 0, 1);
        look("ras_drain", 32'h8000_0310, 1, 32'h8000_0400);
        repeat (2) train(32'h8000_0314, 0, 32'h0, 0, 1);
        train(32'h8003_0000, 1, 32'h8004_0000, 1, 0);
        look("ras_unf_push", 32'h8000_0310, 1, 32'h8003_0008);
        train(32'h8000_0314, 0, 32'h0, 0, 1);
        look("ras_unf_empty", 32'h8000_0310, 1, 32'h8000_0400);
`endif

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst   = ($urandom_range(0, 399) == 0);
            clear = ($urandom_range(0, 149) == 0);
            set   = 1'($urandom_range(0, 1));
            set_pc = pool_pc();
            set_taken = 1'($urandom_range(0, 2) != 0);
            set_target = 32'h9000_0000 | 32'($urandom_range(0, 255) << 2);
            r = $urandom_range(0, 9);
            set_is_call = (r < 2);
            set_is_ret  = (r == 2);
            pc = ($urandom_range(0, 4) == 0) ? 32'($urandom) : pool_pc();
            lookup_pc = pc;
            cycle();
        end
        quiet();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
